// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl
// Assembles bytes from a UART receiver into checked packets of the form
//   SOF_BYTE, LEN, LEN payload bytes, CSUM   (LEN + payload + CSUM == 0 mod 256)
// buffers the payload and hands it on over a valid/ready byte stream.
// Err pulses (bit 3..0): {timeout, overrun-in-drain, bad checksum, bad length}.
// Build option: define UART_RX_PKT_TIMEOUT_EN to enable the inter-byte timeout;
// without it the FSM waits indefinitely for the next byte and Err[3] is 0.

module uart_rx_pkt_ctrl #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CLKS = 416680
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Data_Valid,
    input  logic [7:0] Rx_Byte,
    input  logic       Pkt_Ready,
    output logic       Pkt_Valid,
    output logic [7:0] Pkt_Byte,
    output logic       Pkt_Last,
    output logic [7:0] Pkt_Len,
    output logic [3:0] Err,
    output logic       Busy
);

    // Reject parameter values the datapath cannot represent.
    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("uart_rx_pkt_ctrl: MAX_LEN must be in 1..255");
    end
    if (TIMEOUT_CLKS < 1 || TIMEOUT_CLKS >= (1 << 20)) begin : g_bad_timeout
        $error("uart_rx_pkt_ctrl: TIMEOUT_CLKS must be in 1..2^20-1");
    end

    localparam int         IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_BYTE = 8'(MAX_LEN);

    localparam int ERR_LEN  = 0;
    localparam int ERR_CSUM = 1;
    localparam int ERR_OVR  = 2;
    localparam int ERR_TMO  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [3:0]       err_q, err_d;
    logic             wr_en;
    logic             tmo_hit;

    logic [7:0]       mem_q [MAX_LEN];

    // Byte index widened to the length width; at_last marks buffer[LEN-1].
    logic [7:0]       idx_ext;
    logic             at_last;
    logic [7:0]       csum_total;

    assign idx_ext    = 8'(idx_q);
    assign at_last    = (idx_ext == len_q - 8'd1);
    assign csum_total = sum_q + Rx_Byte;

`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CLKS - 1);

    logic [19:0] tmo_cnt_q, tmo_cnt_d;
    logic        in_frame;

    // The timeout only guards the gap between bytes of an open frame.
    assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    assign tmo_hit  = in_frame && !Data_Valid && (tmo_cnt_q == TMO_LAST);

    // Timeout counter next state: restart on every byte, count while a frame is open.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 20'd1;
        if (Data_Valid || !in_frame || tmo_hit) begin
            tmo_cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Next-state and datapath decode for the framing FSM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        sum_d   = sum_q;
        err_d   = '0;
        wr_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Data_Valid && (Rx_Byte == SOF_BYTE)) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (Data_Valid) begin
                    if ((Rx_Byte == 8'h00) || (Rx_Byte > MAX_BYTE)) begin
                        err_d[ERR_LEN] = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        len_d   = Rx_Byte;
                        sum_d   = Rx_Byte;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                if (Data_Valid) begin
                    wr_en = 1'b1;
                    sum_d = csum_total;
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = S_CSUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_CSUM: begin
                if (Data_Valid) begin
                    idx_d = '0;
                    if (csum_total == 8'h00) begin
                        state_d = S_DRAIN;
                    end else begin
                        err_d[ERR_CSUM] = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end

            S_DRAIN: begin
                // Bytes arriving while the buffer drains have nowhere to go.
                if (Data_Valid) begin
                    err_d[ERR_OVR] = 1'b1;
                end
                if (Pkt_Ready) begin
                    if (at_last) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // A timeout only fires on a cycle with no byte, so it never collides
        // with the other error sources.
        if (tmo_hit) begin
            err_d          = '0;
            err_d[ERR_TMO] = 1'b1;
            idx_d          = '0;
            state_d        = S_IDLE;
        end
    end

    // FSM state and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (Rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    // Payload buffer write port.
    always_ff @(posedge Clk) begin
        // NOTE: the buffer is deliberately not reset; every entry read in DRAIN
        // was written earlier in the same packet, and an unreset array maps
        // onto plain RAM.
        if (wr_en && !Rst) begin
            mem_q[idx_q] <= Rx_Byte;
        end
    end

    assign Pkt_Valid = (state_q == S_DRAIN);
    assign Pkt_Byte  = Pkt_Valid ? mem_q[idx_q] : 8'h00;
    assign Pkt_Last  = Pkt_Valid && at_last;
    assign Pkt_Len   = Pkt_Valid ? len_q : 8'h00;
    assign Err       = err_q;
    assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl
// Directed and randomized frames against a packet-level reference model:
// each frame is classified from the framing rules (length range, modulo-256
// sum) and good payloads are compared byte by byte on the output stream.
// Honours UART_RX_PKT_TIMEOUT_EN to select the timeout scenario.

module tb_uart_rx_pkt_ctrl;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         TMO     = 100;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Data_Valid;
    logic [7:0] Rx_Byte;
    logic       Pkt_Ready;
    logic       Pkt_Valid;
    logic [7:0] Pkt_Byte;
    logic       Pkt_Last;
    logic [7:0] Pkt_Len;
    logic [3:0] Err;
    logic       Busy;

    uart_rx_pkt_ctrl #(
        .MAX_LEN      (MAX_LEN),
        .SOF_BYTE     (SOF),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Data_Valid (Data_Valid),
        .Rx_Byte    (Rx_Byte),
        .Pkt_Ready  (Pkt_Ready),
        .Pkt_Valid  (Pkt_Valid),
        .Pkt_Byte   (Pkt_Byte),
        .Pkt_Last   (Pkt_Last),
        .Pkt_Len    (Pkt_Len),
        .Err        (Err),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] pay [256];
    int         pay_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic [3:0] exp_err);
        Data_Valid = 1'b1;
        Rx_Byte    = b;
        tick();
        Data_Valid = 1'b0;
        Rx_Byte    = 8'h00;
        check({tag, "_err"}, 32'(Err), 32'(exp_err));
    endtask

    task automatic idle(input int n, input logic exp_busy);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_err", 32'(Err), 32'(0));
            check("idle_busy", 32'(Busy), 32'(exp_busy));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(Pkt_Valid), 32'(0));
        check({tag, "_last"}, 32'(Pkt_Last), 32'(0));
        check({tag, "_len"}, 32'(Pkt_Len), 32'(0));
        check({tag, "_busy"}, 32'(Busy), 32'(0));
    endtask

    task automatic check_reset(input string tag);
        check_idle(tag);
        check({tag, "_byte"}, 32'(Pkt_Byte), 32'(0));
        check({tag, "_err"}, 32'(Err), 32'(0));
    endtask

    // Reference model: verdict of a frame from the framing rules alone.
    function automatic logic [3:0] classify(input int len, input int csum);
        int s;
        if (len == 0 || len > MAX_LEN) return 4'b0001;
        s = len + csum;
        for (int i = 0; i < len; i++) s += int'(pay[i]);
        if (s % 256 != 0) return 4'b0010;
        return 4'b0000;
    endfunction

    function automatic int good_csum(input int len);
        int s;
        s = len;
        for (int i = 0; i < len; i++) s += int'(pay[i]);
        return (256 - (s % 256)) % 256;
    endfunction

    // Consume the presented packet and compare it with pay[0..pay_len-1].
    task automatic drain(input int hold, input bit inj_hold, input bit inj_last, input bit rnd);
        int idx;
        int cyc;
        bit rdy;
        bit inj;
        idx = 0;
        cyc = 0;
        while (idx < pay_len && cyc < 500) begin
            check("pkt_valid", 32'(Pkt_Valid), 32'(1));
            check("pkt_byte", 32'(Pkt_Byte), 32'(pay[idx]));
            check("pkt_last", 32'(Pkt_Last), 32'(idx == pay_len - 1));
            check("pkt_len", 32'(Pkt_Len), 32'(pay_len));
            check("drain_busy", 32'(Busy), 32'(1));
            if (cyc < hold) rdy = 1'b0;
            else if (rnd) rdy = ($urandom_range(0, 2) != 0);
            else rdy = 1'b1;
            inj = (inj_hold && cyc == 2) || (inj_last && rdy && idx == pay_len - 1) ||
                  (rnd && $urandom_range(0, 5) == 0);
            Pkt_Ready  = rdy;
            Data_Valid = inj;
            Rx_Byte    = inj ? SOF : 8'h00;
            tick();
            Data_Valid = 1'b0;
            Rx_Byte    = 8'h00;
            check("drain_err", 32'(Err), inj ? 32'(4) : 32'(0));
            if (rdy) idx++;
            cyc++;
        end
        Pkt_Ready = 1'b1;
        check("drain_done", 32'(idx), 32'(pay_len));
        if (hold == 0 && !rnd) check("zero_bubble", 32'(cyc), 32'(pay_len));
        check_idle("post_drain");
    endtask

    // Send one frame whose payload is already in pay[], then check the outcome.
    task automatic send_frame(input int len, input int csum, input int gap_max,
                              input int hold, input bit inj_hold, input bit inj_last,
                              input bit rnd);
        logic [3:0] verdict;
        verdict = classify(len, csum);
        pay_len = len;
        send_byte("sof", SOF, 4'b0000);
        check("sof_busy", 32'(Busy), 32'(1));
        idle($urandom_range(0, gap_max), 1'b1);
        if (verdict == 4'b0001) begin
            send_byte("len_bad", 8'(len), verdict);
            check_idle("len_bad");
            tick();
            check("len_err_single", 32'(Err), 32'(0));
            return;
        end
        send_byte("len", 8'(len), 4'b0000);
        for (int i = 0; i < len; i++) begin
            idle($urandom_range(0, gap_max), 1'b1);
            send_byte("payload", pay[i], 4'b0000);
        end
        idle($urandom_range(0, gap_max), 1'b1);
        send_byte("csum", 8'(csum), verdict);
        if (verdict != 4'b0000) begin
            check_idle("csum_bad");
            tick();
            check("csum_err_single", 32'(Err), 32'(0));
            check("csum_bad_valid", 32'(Pkt_Valid), 32'(0));
            return;
        end
        drain(hold, inj_hold, inj_last, rnd);
    endtask

    // Bound the whole run in case the DUT wedges.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int len;
        int csum;
        int r;
        logic [7:0] junk;

        // Reset with a competing SOF byte and ready asserted.
        Rst        = 1'b1;
        Data_Valid = 1'b1;
        Rx_Byte    = SOF;
        Pkt_Ready  = 1'b1;
        repeat (3) tick();
        check_reset("reset");
        Rst        = 1'b0;
        Data_Valid = 1'b0;
        Rx_Byte    = 8'h00;
        tick();
        check_idle("after_reset");

        // Good 3-byte packet drained back-to-back.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(3, 'h97, 0, 0, 1'b0, 1'b0, 1'b0);

        // Same packet with a bad checksum.
        send_frame(3, 'h98, 0, 0, 1'b0, 1'b0, 1'b0);

        // Zero length and over-long length.
        send_frame(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        send_frame(17, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Stalled drain with a byte injected mid-drain and on the final acceptance.
        pay[0] = 8'h5A; pay[1] = 8'hC3;
        send_frame(2, good_csum(2), 0, 5, 1'b1, 1'b1, 1'b0);

`ifdef UART_RX_PKT_TIMEOUT_EN
        // Inter-byte timeout fires TMO clocks after the last byte.
        send_byte("t_sof", SOF, 4'b0000);
        send_byte("t_len", 8'h02, 4'b0000);
        send_byte("t_p0", 8'h11, 4'b0000);
        idle(TMO - 1, 1'b1);
        tick();
        check("tmo_err", 32'(Err), 32'(8));
        check("tmo_busy", 32'(Busy), 32'(0));
        tick();
        check("tmo_single", 32'(Err), 32'(0));
        pay[0] = 8'h55;
        send_frame(1, 'hAA, 0, 0, 1'b0, 1'b0, 1'b0);
`else
        // Without the timeout the frame survives a long gap.
        send_byte("nt_sof", SOF, 4'b0000);
        send_byte("nt_len", 8'h02, 4'b0000);
        send_byte("nt_p0", 8'h11, 4'b0000);
        idle(150, 1'b1);
        send_byte("nt_p1", 8'h22, 4'b0000);
        send_byte("nt_cs", 8'hCB, 4'b0000);
        pay[0] = 8'h11; pay[1] = 8'h22; pay_len = 2;
        drain(0, 1'b0, 1'b0, 1'b0);
`endif

        // Reset in the middle of a payload, with a byte arriving on the reset edge.
        send_byte("r_sof", SOF, 4'b0000);
        send_byte("r_len", 8'h04, 4'b0000);
        send_byte("r_p0", 8'h11, 4'b0000);
        send_byte("r_p1", 8'h22, 4'b0000);
        Rst        = 1'b1;
        Data_Valid = 1'b1;
        Rx_Byte    = 8'h33;
        tick();
        Rst        = 1'b0;
        Data_Valid = 1'b0;
        Rx_Byte    = 8'h00;
        check_reset("mid_reset");
        tick();
        check("mid_reset_err", 32'(Err), 32'(0));
        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        send_frame(4, good_csum(4), 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized frames: lengths, payloads, corruption, gaps, backpressure.
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == SOF) junk = 8'h00;
                send_byte("junk", junk, 4'b0000);
                check("junk_busy", 32'(Busy), 32'(0));
            end
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(MAX_LEN + 1, 255);
            else len = $urandom_range(1, MAX_LEN);
            for (int i = 0; i < 256; i++) pay[i] = 8'($urandom_range(0, 255));
            csum = good_csum((len <= MAX_LEN) ? len : 0);
            if ($urandom_range(0, 3) == 0) csum = (csum + $urandom_range(1, 255)) % 256;
            send_frame(len, csum, 2, $urandom_range(0, 3), 1'b0, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
